// File: rtl/matmul_ctrl.sv
// -----------------------------------------------------------------------------
// matmul_ctrl -- sequencer for a serial M x N by N x M matrix multiply.
//
// The block only generates addresses and strobes; operand data, the MAC and
// the result memory live outside. One multiply runs through:
//   LOAD_A  : stream A (M x N, row-major) into the A memory, one element per
//             cycle with in_valid=1 (in_valid=0 stalls).
//   LOAD_B  : same for B (N x M, row-major).
//   COMPUTE : M*M*N back-to-back read issues, k innermost, then j, then i.
//   DRAIN   : two cycles to retire the last MAC step and result write.
//   OUTPUT  : read the M*M results back out in address order.
//   DONE    : one-cycle completion pulse, then back to IDLE.
//
// Operand and result memories have a one-cycle read latency, so mac_en,
// mac_clr and out_valid are the corresponding issue flags delayed by one
// cycle; res_we/res_addr trail the last mac_en of each inner product by one.
//
// Handshake: start is sampled only in IDLE; in_valid is sampled only in
// LOAD_A/LOAD_B, and an element is accepted on every such cycle it is 1.
//
// Ports:
//   clk, reset (async, active-low), start, in_valid
//   a_we/a_addr, b_we/b_addr  operand memory write strobes and addresses
//   mac_clr, mac_en           MAC control (aligned with read data)
//   res_we/res_addr           result memory write
//   out_addr, out_valid       result read-out address / data valid
//   busy, done                status
//   state_dbg                 current FSM state encoding (for checkers)
//   perf_cycles               busy-cycle counter, only when MATMUL_CTRL_PERF_EN
//                             is defined
//
// Parameters: DW element width (datapath outside this block), M, N matrix
// dimensions, AW address width with 2**AW >= max(M*N, M*M).
// -----------------------------------------------------------------------------
module matmul_ctrl #(
    parameter int DW = 8,
    parameter int M  = 3,
    parameter int N  = 4,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    output logic          a_we,
    output logic          b_we,
    output logic [AW-1:0] a_addr,
    output logic [AW-1:0] b_addr,
    output logic          mac_clr,
    output logic          mac_en,
    output logic          res_we,
    output logic [AW-1:0] res_addr,
    output logic [AW-1:0] out_addr,
    output logic          out_valid,
    output logic          busy,
    output logic          done,
    output logic [2:0]    state_dbg
`ifdef MATMUL_CTRL_PERF_EN
    ,
    output logic [15:0]   perf_cycles
`endif
);

    // Parameter sanity checks at elaboration time.
    if (DW < 1) begin : g_dw_check
        $error("matmul_ctrl: DW must be at least 1");
    end
    if ((2 ** AW) < M * N || (2 ** AW) < M * M) begin : g_aw_check
        $error("matmul_ctrl: AW too small for M*N or M*M addresses");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_A  = 3'd1,
        S_LOAD_B  = 3'd2,
        S_COMPUTE = 3'd3,
        S_DRAIN   = 3'd4,
        S_OUTPUT  = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    localparam logic [AW-1:0] LOAD_LAST = AW'(M * N - 1);
    localparam logic [AW-1:0] OUT_LAST  = AW'(M * M - 1);
    localparam logic [AW-1:0] IJ_LAST   = AW'(M - 1);
    localparam logic [AW-1:0] K_LAST    = AW'(N - 1);
    localparam logic [AW-1:0] M_AW      = AW'(M);
    localparam logic [AW-1:0] N_AW      = AW'(N);

    state_t        state, state_nxt;
    logic [AW-1:0] cnt;            // load element index / output address
    logic [AW-1:0] ci, cj, ck;     // compute loop counters
    logic          drain_cnt;
    logic          rd_issue;       // operand read issued this cycle
    logic          out_issue;      // result read issued this cycle

    // Pipeline stage aligned with operand read data.
    logic          issue_q, clr_q, last_q;
    logic [AW-1:0] raddr_q;
    // Result write stage.
    logic          res_we_q;
    logic [AW-1:0] res_addr_q;
    logic          out_valid_q;

    // ------------------------------------------------------------------
    // Next-state and combinational outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        a_we      = 1'b0;
        b_we      = 1'b0;
        a_addr    = '0;
        b_addr    = '0;
        out_addr  = '0;
        rd_issue  = 1'b0;
        out_issue = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_LOAD_A;
            end
            S_LOAD_A: begin
                a_addr = cnt;
                a_we   = in_valid;
                if (in_valid && cnt == LOAD_LAST) state_nxt = S_LOAD_B;
            end
            S_LOAD_B: begin
                b_addr = cnt;
                b_we   = in_valid;
                if (in_valid && cnt == LOAD_LAST) state_nxt = S_COMPUTE;
            end
            S_COMPUTE: begin
                a_addr   = ci * N_AW + ck;
                b_addr   = ck * M_AW + cj;
                rd_issue = 1'b1;
                if (ci == IJ_LAST && cj == IJ_LAST && ck == K_LAST)
                    state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_cnt) state_nxt = S_OUTPUT;
            end
            S_OUTPUT: begin
                out_addr  = cnt;
                out_issue = 1'b1;
                if (cnt == OUT_LAST) state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            ci        <= '0;
            cj        <= '0;
            ck        <= '0;
            drain_cnt <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_LOAD_A, S_LOAD_B: begin
                    if (in_valid) cnt <= (cnt == LOAD_LAST) ? '0 : cnt + 1'b1;
                end
                S_OUTPUT: begin
                    cnt <= (cnt == OUT_LAST) ? '0 : cnt + 1'b1;
                end
                default: cnt <= '0;
            endcase
            if (state == S_COMPUTE) begin
                if (ck == K_LAST) begin
                    ck <= '0;
                    if (cj == IJ_LAST) begin
                        cj <= '0;
                        ci <= (ci == IJ_LAST) ? '0 : ci + 1'b1;
                    end else begin
                        cj <= cj + 1'b1;
                    end
                end else begin
                    ck <= ck + 1'b1;
                end
            end
            drain_cnt <= (state == S_DRAIN) ? ~drain_cnt : 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Read-latency pipeline: MAC control and result write
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issue_q     <= 1'b0;
            clr_q       <= 1'b0;
            last_q      <= 1'b0;
            raddr_q     <= '0;
            res_we_q    <= 1'b0;
            res_addr_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            issue_q     <= rd_issue;
            clr_q       <= rd_issue && (ck == '0);
            last_q      <= rd_issue && (ck == K_LAST);
            raddr_q     <= ci * M_AW + cj;
            res_we_q    <= issue_q && last_q;
            // Only refresh the visible result address when it is written.
            if (issue_q && last_q) res_addr_q <= raddr_q;
            out_valid_q <= out_issue;
        end
    end

    assign mac_en    = issue_q;
    assign mac_clr   = clr_q;
    assign res_we    = res_we_q;
    assign res_addr  = res_addr_q;
    assign out_valid = out_valid_q;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign state_dbg = state;

`ifdef MATMUL_CTRL_PERF_EN
    // Busy-cycle counter: cleared when a start is accepted, counts every
    // non-IDLE cycle, saturates, and holds its value while idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_cycles <= '0;
        end else if (state == S_IDLE) begin
            if (start) perf_cycles <= '0;
        end else if (perf_cycles != 16'hFFFF) begin
            perf_cycles <= perf_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: doc/matmul_ctrl.md
MATMUL_CTRL -- requirements
Module: matmul_ctrl

Interface
REQ-001 Parameter DW, default 8: element width of the sequenced datapath (pass-through only; no arithmetic here).
REQ-002 Parameter M, default 3: rows of A, columns of B; result is M x M.
REQ-003 Parameter N, default 4: columns of A, rows of B; inner-product length.
REQ-004 Parameter AW, default 8: address width, SHALL satisfy 2^AW >= max(M*N, M*M).
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-007 start  input  1  request to begin a multiply; honoured only in IDLE.
REQ-008 in_valid  input  1  current serial input element valid during load.
REQ-009 a_we, b_we  output  1 each  write strobes for the A / B operand memories.
REQ-010 a_addr, b_addr  output  AW each  operand memory address (write during load, read during compute).
REQ-011 mac_clr  output  1  MAC loads the product instead of accumulating.
REQ-012 mac_en  output  1  MAC consumes the operand pair read in the previous cycle.
REQ-013 res_we  output  1  write accumulator to result memory; res_addr  output  AW.
REQ-014 out_addr  output  AW  result memory read address; out_valid  output  1  data_out valid.
REQ-015 busy  output  1  high in any state except IDLE; done  output  1  one-cycle completion pulse.

Function
REQ-016 FSM states: IDLE, LOAD_A, LOAD_B, COMPUTE, DRAIN, OUTPUT, DONE.
REQ-017 IDLE: start=1 -> LOAD_A next cycle; start while busy SHALL be ignored.
REQ-018 LOAD_A: each cycle with in_valid=1 -> a_we=1, a_addr=count (0..M*N-1, row-major), count++; in_valid=0 -> a_we=0, count held (stall); after element M*N-1 -> LOAD_B, count=0.
REQ-019 LOAD_B: identical rule for B (N x M, row-major) with b_we; after element N*M-1 -> COMPUTE.
REQ-020 COMPUTE: counters i,j (0..M-1), k (0..N-1), k innermost, then j, then i; each cycle a_addr=i*N+k, b_addr=k*M+j; exactly M*M*N cycles, no bubbles.
REQ-021 Read latency is 1: mac_en is the read-issue flag delayed 1 cycle; mac_clr=1 with the mac_en of k=0.
REQ-022 res_we=1 one cycle after the mac_en of k=N-1, with res_addr=i*M+j of that element (registered copy).
REQ-023 DRAIN: 2 cycles to retire the last mac_en and res_we, then OUTPUT.
REQ-024 OUTPUT: out_addr steps 0..M*M-1, one per cycle; out_valid = issue flag delayed 1 cycle; after last address -> DONE.
REQ-025 DONE: done=1 for exactly one cycle (coincides with last out_valid), then IDLE.
REQ-026 Write strobes, mac_en, res_we, out_valid SHALL be 0 in every state not listed as driving them.
REQ-027 Address arithmetic computed at AW bits; counters wrap to 0 only at their stated limits.
REQ-028 in_valid is ignored outside LOAD_A/LOAD_B; start asserted in DONE is ignored.

Reset
REQ-029 reset=0 mid-operation SHALL abort to IDLE asynchronously, discarding partial results.
REQ-030 Reset values: state IDLE, all counters 0, all addresses 0, all strobes 0, busy=0, done=0, perf_cycles=0.

Configuration
REQ-031 Macro MATMUL_CTRL_PERF_EN defined: adds output perf_cycles[15:0], cleared on start acceptance, incremented each non-IDLE cycle, saturating at 16'hFFFF, held in IDLE until next start.
REQ-032 Macro undefined: port perf_cycles and its counter SHALL not exist; all other behaviour identical.

Verification (M=3, N=4)
REQ-033 reset low, then start pulse, in_valid=1 continuous, data 0..11 twice -> a_we for 12 cycles addr 0..11, b_we 12 cycles addr 0..11, done 72 cycles after start accepted, perf_cycles=72.
REQ-034 Compute trace -> first res_we res_addr=0 on 5th cycle after COMPUTE entry; 9 res_we total, res_addr 0..8; mac_clr count 9; mac_en count 36.
REQ-035 in_valid low on every other load cycle -> load takes 48 cycles, addresses unchanged order, done at cycle 96, perf_cycles=96.
REQ-036 reset pulled low during COMPUTE (i=1) -> busy=0 and all strobes 0 immediately; new start re-runs from LOAD_A addr 0.
REQ-037 start held high through the whole run -> exactly one done per run, second run starts the cycle after returning to IDLE.
